dma_csr_responder: RTL
======================

# dma_csr_responder

Avalon-MM slave that implements the DMA control/status register file programmed by the custom-instruction DMA setup master, plus the transfer sequencer behind it. It decodes byte-addressed register writes (read address, write address, length, control), starts a transfer on GO and emits one transfer request per beat on a valid/ready port toward the datapath. It then reports completion through STATUS and an interrupt. It sits on the same Avalon fabric as the Nios II, at the responder end of the DMA setup write sequence.

## Interface

- M_ADDR_WIDTH, 32, width of read/write address registers and request addresses
- LEN_WIDTH, 32, width of LENGTH register (bytes)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- slave_address  in  5  byte address: 0 STATUS, 4 READADDR, 8 WRITEADDR, 12 LENGTH, 24 CONTROL
- slave_chipselect  in  1  access qualifier
- slave_write  in  1  write strobe
- slave_read  in  1  read strobe
- slave_writedata  in  32  write data
- slave_readdata  out  32  read data, valid when read and !waitrequest
- slave_waitrequest  out  1  stall current access
- req_valid  out  1  beat request valid
- req_ready  in  1  datapath accepts beat
- req_rd_address  out  M_ADDR_WIDTH  source address of beat
- req_wr_address  out  M_ADDR_WIDTH  destination address of beat
- req_size  out  3  beat size in bytes (1, 2, 4)
- irq  out  1  DONE & CONTROL.I_EN

## Operation

- Access = chipselect & (write | read); unmapped addresses: writes ignored, reads return 0.
- STATUS (RO except clear): bit0 DONE, bit1 BUSY, bit4 LEN (LENGTH==0); others 0. Any write to STATUS clears DONE.
- CONTROL holds bits [9:0]: 0 BYTE, 1 HW, 2 WORD, 3 GO, 4 I_EN, 5 REEN, 6 WEEN, 7 LEEN, 8 RCON, 9 WCON; bits [31:10] read 0. REEN/WEEN/LEEN are stored and read back only.
- Beat size: WORD→4 else HW→2 else BYTE→1; none set → 4.
- Engine states: E_IDLE, E_RUN.
  - E_IDLE→E_RUN: CONTROL write with GO=1 and LENGTH≠0. BUSY=1, DONE=0.
  - CONTROL write with GO=1 and LENGTH==0: DONE=1 at once, GO cleared, no beats.
  - E_RUN: req_valid=1 with current READADDR/WRITEADDR/size. On req_valid&req_ready: LENGTH -= min(size, LENGTH); READADDR += size unless RCON; WRITEADDR += size unless WCON.
  - The handshake that takes LENGTH to 0 → E_IDLE next cycle: BUSY=0, DONE=1, CONTROL.GO cleared.
- Writes to READADDR/WRITEADDR/LENGTH/CONTROL while BUSY: waitrequest held high until the engine returns to E_IDLE, then the write completes. Writes to STATUS and all reads never stall on BUSY.
- Slave FSM states: S_IDLE, S_RDATA. A read in S_IDLE: waitrequest=1, register the selected value, go to S_RDATA. S_RDATA: waitrequest=0, readdata valid, return to S_IDLE.

## Timing

- Reset values: all registers 0, slave_readdata 0, slave_waitrequest 0 when no access, req_valid 0, req addresses 0, req_size 4, irq 0.
- Reset mid-transfer: engine to E_IDLE at once, req_valid drops asynchronously, registers cleared, no DONE.
- Non-stalled write: zero wait states, register updated at the cycle's rising edge.
- Read: exactly one wait state; readdata shows register value as of the first cycle.
- GO write at edge N → req_valid high in cycle N+1. One beat per cycle at full throughput while req_ready=1.
- req_valid stays high and req_* stay stable while req_ready=0.
- irq rises the cycle after DONE sets. It falls the cycle after a STATUS write or an I_EN clear.
- Address and LENGTH arithmetic wraps modulo register width; LENGTH never underflows.

## Structure

- Shared package dma_csr_pkg: register byte offsets (0, 4, 8, 12, 24), CONTROL and STATUS bit indices, engine and slave state encodings.
- One sub-module, dma_beat_engine: the E_IDLE/E_RUN sequencer and its address/length counters. The top module holds the register decode and the slave FSM.

## Test plan

- Write 4←0x100, 8←0x0, 12←16, 24←0x14C, req_ready=1 → 4 beats; rd 0x100 constant; wr 0x0, 0x4, 0x8, 0xC; size 4. Then STATUS read → 0x11, irq 0.
- LENGTH=6, CONTROL=0x00C → beats of size 4 then 4 with LENGTH 6→2→0. Second beat is final. DONE set.
- CONTROL=0x01A (HW, GO, I_EN), LENGTH=4, req_ready toggled 1/0 → 2 beats held stable while stalled; irq=1 after last; STATUS write → irq 0.
- LENGTH write while BUSY → waitrequest stays high until DONE. The write lands afterward and LENGTH reads back the written value.
- GO with LENGTH=0 → no req_valid, DONE=1 next cycle. Read of address 28 → 0 after one wait state.
- Assert reset_n=0 mid-transfer → req_valid 0 immediately, all registers read 0 after release.

Source files
------------

// File: rtl/dma_csr_pkg.sv
// rtl/dma_csr_pkg.sv - Shared register map, bit indices and state encodings for the DMA CSR block.
package dma_csr_pkg;

   localparam logic [4:0] ADDR_STATUS    = 5'd0;
   localparam logic [4:0] ADDR_READADDR  = 5'd4;
   localparam logic [4:0] ADDR_WRITEADDR = 5'd8;
   localparam logic [4:0] ADDR_LENGTH    = 5'd12;
   localparam logic [4:0] ADDR_CONTROL   = 5'd24;

   localparam int CTL_BYTE = 0;
   localparam int CTL_HW   = 1;
   localparam int CTL_WORD = 2;
   localparam int CTL_GO   = 3;
   localparam int CTL_IEN  = 4;
   localparam int CTL_REEN = 5;
   localparam int CTL_WEEN = 6;
   localparam int CTL_LEEN = 7;
   localparam int CTL_RCON = 8;
   localparam int CTL_WCON = 9;
   localparam int CTL_W    = 10;

   localparam int ST_DONE = 0;
   localparam int ST_BUSY = 1;
   localparam int ST_LEN  = 4;

   localparam logic [0:0] E_IDLE  = 1'b0;
   localparam logic [0:0] E_RUN   = 1'b1;
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_RDATA = 1'b1;

   // Widest selected size wins; an empty size field defaults to a word.
   function automatic logic [2:0] beat_size(input logic [CTL_W-1:0] ctl);
      if (ctl[CTL_WORD])      return 3'd4;
      else if (ctl[CTL_HW])   return 3'd2;
      else if (ctl[CTL_BYTE]) return 3'd1;
      else                    return 3'd4;
   endfunction

endpackage

// File: rtl/dma_beat_engine.sv
// rtl/dma_beat_engine.sv - Transfer sequencer holding the address/length counters and issuing one request per beat.
module dma_beat_engine
   import dma_csr_pkg::*;
#(
   parameter int M_ADDR_WIDTH = 32,
   parameter int LEN_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ld_rd,
   input  logic                    ld_wr,
   input  logic                    ld_len,
   input  logic [31:0]             wdata,
   input  logic                    start,
   input  logic [2:0]              size,
   input  logic                    rcon,
   input  logic                    wcon,
   input  logic                    req_ready,
   output logic                    req_valid,
   output logic [M_ADDR_WIDTH-1:0] rd_addr,
   output logic [M_ADDR_WIDTH-1:0] wr_addr,
   output logic [LEN_WIDTH-1:0]    length,
   output logic                    busy,
   output logic                    finish
);

   logic [0:0]              state_q, state_d;
   logic [M_ADDR_WIDTH-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [LEN_WIDTH-1:0]    size_len;

   always_comb begin
      state_d  = state_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      len_d    = len_q;
      finish   = 1'b0;
      size_len = LEN_WIDTH'(size);
      if (state_q == E_IDLE) begin
         if (ld_rd)  rd_d  = wdata[M_ADDR_WIDTH-1:0];
         if (ld_wr)  wr_d  = wdata[M_ADDR_WIDTH-1:0];
         if (ld_len) len_d = wdata[LEN_WIDTH-1:0];
         if (start)  state_d = E_RUN;
      end else if (req_ready) begin
         // A short tail beat consumes only what is left, so LENGTH never underflows.
         if (len_q <= size_len) begin
            len_d   = '0;
            state_d = E_IDLE;
            finish  = 1'b1;
         end else begin
            len_d = len_q - size_len;
         end
         if (!rcon) rd_d = rd_q + M_ADDR_WIDTH'(size);
         if (!wcon) wr_d = wr_q + M_ADDR_WIDTH'(size);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= E_IDLE;
         rd_q    <= '0;
         wr_q    <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         len_q   <= len_d;
      end
   end

   assign req_valid = (state_q == E_RUN);
   assign busy      = (state_q == E_RUN);
   assign rd_addr   = rd_q;
   assign wr_addr   = wr_q;
   assign length    = len_q;

endmodule

// File: rtl/dma_csr_responder.sv
// rtl/dma_csr_responder.sv - Avalon-MM DMA register file with slave read FSM, fronting the beat engine.
module dma_csr_responder
   import dma_csr_pkg::*;
#(
   parameter int M_ADDR_WIDTH = 32,
   parameter int LEN_WIDTH    = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4:0]              slave_address,
   input  logic                    slave_chipselect,
   input  logic                    slave_write,
   input  logic                    slave_read,
   input  logic [31:0]             slave_writedata,
   output logic [31:0]             slave_readdata,
   output logic                    slave_waitrequest,
   output logic                    req_valid,
   input  logic                    req_ready,
   output logic [M_ADDR_WIDTH-1:0] req_rd_address,
   output logic [M_ADDR_WIDTH-1:0] req_wr_address,
   output logic [2:0]              req_size,
   output logic                    irq
);

   logic [CTL_W-1:0]        control_q, control_d;
   logic                    done_q, done_d;
   logic [0:0]              slv_q, slv_d;
   logic [31:0]             rdata_q, rdata_d;

   logic                    wr_acc, rd_acc, stall_addr, wr_stall, wr_en;
   logic                    go_wr, start, len_zero;
   logic                    ld_rd, ld_wr, ld_len;
   logic [31:0]             rd_mux;
   logic                    busy, finish;
   logic [M_ADDR_WIDTH-1:0] rd_addr, wr_addr;
   logic [LEN_WIDTH-1:0]    length;

   always_comb begin
      wr_acc     = slave_chipselect & slave_write;
      rd_acc     = slave_chipselect & slave_read & ~slave_write;
      stall_addr = (slave_address == ADDR_READADDR) | (slave_address == ADDR_WRITEADDR) |
                   (slave_address == ADDR_LENGTH)   | (slave_address == ADDR_CONTROL);
      // Programming writes wait out a running transfer; STATUS writes and reads never do.
      wr_stall   = wr_acc & busy & stall_addr;
      wr_en      = wr_acc & ~wr_stall;
      slave_waitrequest = rd_acc ? (slv_q == S_IDLE) : wr_stall;

      ld_rd    = wr_en & (slave_address == ADDR_READADDR);
      ld_wr    = wr_en & (slave_address == ADDR_WRITEADDR);
      ld_len   = wr_en & (slave_address == ADDR_LENGTH);
      len_zero = (length == '0);
      go_wr    = wr_en & (slave_address == ADDR_CONTROL) & slave_writedata[CTL_GO];
      start    = go_wr & ~len_zero;

      control_d = control_q;
      if (wr_en && slave_address == ADDR_CONTROL) control_d = slave_writedata[CTL_W-1:0];
      if ((go_wr && len_zero) || finish)          control_d[CTL_GO] = 1'b0;

      done_d = done_q;
      if (wr_en && slave_address == ADDR_STATUS) done_d = 1'b0;
      if (start)                                 done_d = 1'b0;
      if ((go_wr && len_zero) || finish)         done_d = 1'b1;

      rd_mux = 32'd0;
      case (slave_address)
         ADDR_STATUS: begin
            rd_mux[ST_DONE] = done_q;
            rd_mux[ST_BUSY] = busy;
            rd_mux[ST_LEN]  = len_zero;
         end
         ADDR_READADDR:  rd_mux = 32'(rd_addr);
         ADDR_WRITEADDR: rd_mux = 32'(wr_addr);
         ADDR_LENGTH:    rd_mux = 32'(length);
         ADDR_CONTROL:   rd_mux = 32'(control_q);
         default:        rd_mux = 32'd0;
      endcase

      slv_d   = slv_q;
      rdata_d = rdata_q;
      if (slv_q == S_IDLE) begin
         if (rd_acc) begin
            rdata_d = rd_mux;
            slv_d   = S_RDATA;
         end
      end else begin
         slv_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         control_q <= '0;
         done_q    <= 1'b0;
         slv_q     <= S_IDLE;
         rdata_q   <= '0;
      end else begin
         control_q <= control_d;
         done_q    <= done_d;
         slv_q     <= slv_d;
         rdata_q   <= rdata_d;
      end
   end

   dma_beat_engine #(
      .M_ADDR_WIDTH(M_ADDR_WIDTH),
      .LEN_WIDTH   (LEN_WIDTH)
   ) u_engine (
      .clk      (clk),
      .reset_n  (reset_n),
      .ld_rd    (ld_rd),
      .ld_wr    (ld_wr),
      .ld_len   (ld_len),
      .wdata    (slave_writedata),
      .start    (start),
      .size     (req_size),
      .rcon     (control_q[CTL_RCON]),
      .wcon     (control_q[CTL_WCON]),
      .req_ready(req_ready),
      .req_valid(req_valid),
      .rd_addr  (rd_addr),
      .wr_addr  (wr_addr),
      .length   (length),
      .busy     (busy),
      .finish   (finish)
   );

   assign req_size       = beat_size(control_q);
   assign req_rd_address = rd_addr;
   assign req_wr_address = wr_addr;
   assign slave_readdata = rdata_q;
   assign irq            = done_q & control_q[CTL_IEN];

endmodule
